// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder walks the operands LSB first,
// producing a registered sum, carry-out and two's-complement overflow flag.

// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = WIDTH - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            load;
  logic            last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  // Holds the first WIDTH-1 result bits; the final bit comes straight from
  // the adder on the completing edge, so no full-width staging is needed.
  logic [PW-1:0]    part;

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial shifting and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      part  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sr  <= op_a;
      b_sr  <= op_b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      part  <= PW'({fa_s, part} >> 1);
      if (last) begin
        sum  <= {fa_s, part};
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a plain-arithmetic
// reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Reference: returns {ovf, cout, sum} from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int unsigned u;
    int          s;
    logic        o;
    u = int'(a) + int'(b) + int'(c);
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    o = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    return {o, u[W:0]};
  endfunction

  // Present an operation and release start just after the accepting edge,
  // scrambling the operand inputs so a late capture would corrupt the result.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Cycles (negedges) from the accepting edge until done; -1 on timeout.
  task automatic wait_done(output int lat, output int busy_err);
    lat      = -1;
    busy_err = 0;
    for (int k = 0; k < 4 * W; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_err++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, cout, ovf, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               busy, done, cout, ovf, sum);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_holds_idle: got busy=%b, want 0", busy);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } vec_t;

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    int lat;
    int be;
    logic [W+1:0] exp;
    exp = model(a, b, c);
    launch(a, b, c);
    wait_done(lat, be);
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, W);
    end
    n_checks++;
    if (be != 0) begin
      n_fail++;
      $display("FAIL %s_busy: got %0d cycles without busy, want 0", name, be);
    end
    n_checks++;
    if ({ovf, cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL %s_result: a=%h b=%h c=%b got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
               name, a, b, c, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: got done=%b busy=%b one cycle after done, want 0 0",
               name, done, busy);
    end
  endtask

  task automatic test_vectors();
    vec_t vecs[6];
    vecs = '{'{8'h0F, 8'h01, 1'b0}, '{8'hFF, 8'h01, 1'b0}, '{8'h7F, 8'h01, 1'b0},
             '{8'h80, 8'h80, 1'b0}, '{8'h00, 8'h00, 1'b1}, '{8'hFF, 8'hFF, 1'b1}};
    foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c);
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 25; i++) begin
      run_one("rand", W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int pulses;
    logic [W+1:0] exp;
    exp    = model(8'hC3, 8'h5A, 1'b1);
    lat    = -1;
    pulses = 0;
    launch(8'hC3, 8'h5A, 1'b1);
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k == 3) begin
        start = 1'b1;
        op_a  = 8'h11;
        op_b  = 8'h22;
        cin   = 1'b0;
      end
      if (k == 4) start = 1'b0;
    end
    n_checks++;
    if (pulses != 1 || lat != W) begin
      n_fail++;
      $display("FAIL ignore_start_done: got %0d pulses at %0d, want 1 at %0d", pulses, lat, W);
    end
    n_checks++;
    if ({ovf, cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL ignore_start_result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
               ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    int be;
    pulses = 0;
    launch(8'h12, 8'h34, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, cout, ovf, sum} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               busy, done, cout, ovf, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_checks++;
    if (pulses != 0 || sum !== '0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles sum=%h, want 0 and 00", pulses, sum);
    end
    launch(8'h12, 8'h34, 1'b0);
    wait_done(lat, be);
    n_checks++;
    if (lat != W || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rerun: got lat=%0d sum=%h cout=%b ovf=%b, want lat=%0d sum=46 cout=0 ovf=0",
               lat, sum, cout, ovf, W);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int be;
    int hold_err;
    logic [W+1:0] exp1;
    logic [W+1:0] exp2;
    exp1     = model(8'hAA, 8'h55, 1'b1);
    exp2     = model(8'h01, 8'h02, 1'b0);
    hold_err = 0;
    launch(8'hAA, 8'h55, 1'b1);
    wait_done(lat, be);
    n_checks++;
    if (lat != W || {ovf, cout, sum} !== exp1) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d ovf=%b cout=%b sum=%h, want lat=%0d ovf=%b cout=%b sum=%h",
               lat, ovf, cout, sum, W, exp1[W+1], exp1[W], exp1[W-1:0]);
    end
    op_a  = 8'h01;
    op_b  = 8'h02;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if ({ovf, cout, sum} !== exp1 || done !== 1'b0 || busy !== 1'b1) hold_err++;
    end
    n_checks++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d cycles with changed result or wrong status, want 0", hold_err);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || {ovf, cout, sum} !== exp2) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b ovf=%b cout=%b sum=%h, want done=1 ovf=%b cout=%b sum=%h",
               done, ovf, cout, sum, exp2[W+1], exp2[W], exp2[W-1:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition, sampled on the rising edge of clk.
REQ-005 The block SHALL have port op_a, input, WIDTH bits: operand A, sampled with start.
REQ-006 The block SHALL have port op_b, input, WIDTH bits: operand B, sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking result completion.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out of the MSB.
REQ-012 The block SHALL have port ovf, output, 1 bit: registered two's-complement overflow flag.

Function
REQ-013 The block SHALL contain exactly one full_adder instance, which SHALL be the only arithmetic element; the addition is performed bit-serially, LSB first.
REQ-014 The block SHALL implement a state machine with three states:
- IDLE, encoded 2'b00
- RUN, encoded 2'b01
- DONE, encoded 2'b10
- Unused encodings SHALL return to IDLE on the next edge.
REQ-015 In IDLE or DONE, when start=1 at an edge, the block SHALL:
- load op_a and op_b into the A and B shift registers
- load cin into the carry register
- clear the bit counter to 0
- enter RUN.
REQ-016 In RUN, the full_adder inputs SHALL be A[0], B[0] and the carry register.
REQ-017 On each RUN edge, the block SHALL:
- shift A and B right by one bit
- shift the full_adder sum bit into the MSB of the partial-result register
- load the full_adder carry-out into the carry register
- increment the counter.
REQ-018 On the RUN edge that processes bit WIDTH-1, the block SHALL:
- load sum from the partial-result register (including this final bit)
- load cout from the final carry-out
- load ovf as (carry into the MSB) XOR (carry out of the MSB)
- enter DONE.
REQ-019 Latency: with start accepted at edge n, done SHALL be 1 between edges n+WIDTH and n+WIDTH+1 (8 cycles for WIDTH=8).
REQ-020 busy SHALL be 1 exactly while in RUN, and done SHALL be 1 exactly while in DONE; both are decoded from the state register only, with no combinational input paths.
REQ-021 From DONE, the block SHALL enter IDLE after one cycle if start=0, or RUN if start=1 (back-to-back operation; no idle cycle is required).
REQ-022 start asserted while in RUN SHALL be ignored, with no effect on state, operands or counter.
REQ-023 Changes on op_a, op_b or cin after the accepting edge SHALL NOT affect the result in progress.
REQ-024 sum, cout and ovf SHALL hold their values from the previous completion until the next completion edge, including throughout a following RUN.
REQ-025 The result SHALL equal {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1).

Reset
REQ-026 While rst=1, the block SHALL asynchronously force:
- state to IDLE
- busy=0, done=0
- sum=0, cout=0, ovf=0
- the shift registers, carry register and counter to 0.
REQ-027 A reset during RUN SHALL abort the operation; no done pulse SHALL occur for the aborted operation.
REQ-028 The first start accepted after rst deasserts SHALL behave exactly as from IDLE.

Verification
REQ-029 The bench SHALL cover: op_a=0x0F, op_b=0x01, cin=0 -> done 8 cycles after start; sum=0x10, cout=0, ovf=0.
REQ-030 The bench SHALL cover: op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-031 The bench SHALL cover: op_a=0x7F, op_b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; and op_a=0x80, op_b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-032 The bench SHALL cover start pulsed again, and op_a/op_b changed, at RUN cycle 3 -> ignored, with the original result and a single done pulse.
REQ-033 The bench SHALL cover rst pulsed at RUN cycle 4 of 0x12+0x34 -> all outputs 0 with no done; a following 0x12+0x34 -> sum=0x46.
REQ-034 The bench SHALL cover 0xAA+0x55 with cin=1, followed by start held during DONE with 0x01+0x02 -> first result sum=0x00, cout=1; sum holds 0x00 during the second RUN, then shows 0x03 with a second done exactly 8 cycles later.
